bicubic_weight_gen: RTL and testbench



---
 rtl/bicubic_weight_gen.sv | 153 +++++++++++++++
 tb/tb_bicubic_weight_gen.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bicubic_weight_gen.sv
// Pipelined Keys cubic-convolution weight generator: four tap weights per phase,
// per-beat coefficient, bilinear fallback, unity-sum normalisation, valid/ready flow.
module bicubic_weight_gen #(
  parameter int FRAC_W = 8,
  parameter int COEF_W = FRAC_W + 3,
  parameter int WGT_W  = FRAC_W + 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [FRAC_W-1:0]        frac,
  input  logic signed [COEF_W-1:0] coeff_a,
  input  logic                     mode,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [WGT_W-1:0]  w0,
  output logic signed [WGT_W-1:0]  w1,
  output logic signed [WGT_W-1:0]  w2,
  output logic signed [WGT_W-1:0]  w3
);

  localparam int PW = COEF_W + FRAC_W + 8;
  localparam int TW = FRAC_W + 1;
  localparam int SW = 2 * FRAC_W + 1;

  localparam logic signed [PW-1:0] ONE   = {{(PW-FRAC_W-1){1'b0}}, 1'b1, {FRAC_W{1'b0}}};
  localparam logic signed [PW-1:0] HALF  = {{(PW-FRAC_W){1'b0}}, 1'b1, {(FRAC_W-1){1'b0}}};
  localparam logic signed [PW-1:0] TWO   = ONE <<< 1;
  localparam logic signed [PW-1:0] THREE = ONE + TWO;
  localparam logic signed [PW-1:0] WMAX  = {{(PW-WGT_W+1){1'b0}}, {(WGT_W-1){1'b1}}};
  localparam logic signed [PW-1:0] WMIN  = ~WMAX;

  // Handshake: a beat moves on an edge where in_valid && in_ready; the output set is
  // consumed on an edge where out_valid && out_ready. in_ready doubles as the global
  // pipeline advance, so every rank freezes together while the output is stalled.
  logic advance;
  assign in_ready = !out_valid || out_ready;
  assign advance  = in_ready;

  function automatic logic signed [PW-1:0] rnd(input logic signed [PW-1:0] x);
    return (x + HALF) >>> FRAC_W;
  endfunction

  function automatic logic signed [WGT_W-1:0] sat(input logic signed [PW-1:0] x);
    if (x > WMAX)      return WGT_W'(WMAX);
    else if (x < WMIN) return WGT_W'(WMIN);
    else               return WGT_W'(x);
  endfunction

  // Rank 1: registered beat
  logic                     v1, m1;
  logic [FRAC_W-1:0]        f1;
  logic signed [COEF_W-1:0] a1;
  // Rank 2: t^2
  logic                     v2, m2;
  logic [FRAC_W-1:0]        f2;
  logic signed [COEF_W-1:0] a2;
  logic [TW-1:0]            t2_2;
  // Rank 3: t^3
  logic                     v3, m3;
  logic [FRAC_W-1:0]        f3;
  logic signed [COEF_W-1:0] a3;
  logic [TW-1:0]            t2_3, t3_3;
  // Rank 4: weight products
  logic                     v4;
  logic signed [PW-1:0]     w0_4, w2_4, w3_4;

  logic [TW-1:0] t2_next, t3_next;
  assign t2_next = TW'((SW'(f1) * SW'(f1) + SW'(1 << (FRAC_W - 1))) >> FRAC_W);
  assign t3_next = TW'((SW'(t2_2) * SW'(f2) + SW'(1 << (FRAC_W - 1))) >> FRAC_W);

  logic signed [PW-1:0] ts, s2, s3, as, poly0, poly3, c1, c2, c3;
  logic signed [PW-1:0] w0_n, w2_n, w3_n;

  always_comb begin
    ts    = {{(PW-FRAC_W){1'b0}}, f3};
    s2    = {{(PW-TW){1'b0}}, t2_3};
    s3    = {{(PW-TW){1'b0}}, t3_3};
    as    = {{(PW-COEF_W){a3[COEF_W-1]}}, a3};
    poly0 = s3 - (s2 <<< 1) + ts;
    poly3 = s2 - s3;
    c1    = -as;
    c2    = (as <<< 1) + THREE;
    c3    = -(as + TWO);
    if (m3) begin
      w0_n = '0;
      w3_n = '0;
      w2_n = ts;
    end else begin
      w0_n = rnd(as * poly0);
      w3_n = rnd(as * poly3);
      w2_n = rnd(c1 * ts) + rnd(c2 * s2) + rnd(c3 * s3);
    end
  end

  // w1 is formed from the already-saturated outer weights so the set sums to one
  logic signed [WGT_W-1:0] s0_n, s2_n, s3_n, s1_n;
  logic signed [PW-1:0]    w1_full;

  always_comb begin
    s0_n    = sat(w0_4);
    s2_n    = sat(w2_4);
    s3_n    = sat(w3_4);
    w1_full = ONE - PW'(s0_n) - PW'(s2_n) - PW'(s3_n);
    s1_n    = sat(w1_full);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      v3        <= 1'b0;
      v4        <= 1'b0;
      out_valid <= 1'b0;
      w0        <= '0;
      w1        <= '0;
      w2        <= '0;
      w3        <= '0;
    end else if (advance) begin
      v1        <= in_valid;
      v2        <= v1;
      v3        <= v2;
      v4        <= v3;
      out_valid <= v4;
      w0        <= s0_n;
      w1        <= s1_n;
      w2        <= s2_n;
      w3        <= s3_n;
    end
  end

  always_ff @(posedge clk) begin
    if (advance) begin
      f1   <= frac;
      a1   <= coeff_a;
      m1   <= mode;
      f2   <= f1;
      a2   <= a1;
      m2   <= m1;
      t2_2 <= t2_next;
      f3   <= f2;
      a3   <= a2;
      m3   <= m2;
      t2_3 <= t2_2;
      t3_3 <= t3_next;
      w0_4 <= w0_n;
      w2_4 <= w2_n;
      w3_4 <= w3_n;
    end
  end

endmodule

// File: tb/tb_bicubic_weight_gen.sv
// Bench for bicubic_weight_gen: directed identity/midpoint/bilinear sets, a unity-sum
// sweep, randomized backpressure traffic and reset cases against an arithmetic model.
module tb_bicubic_weight_gen;

  localparam int F  = 8;
  localparam int CW = F + 3;
  localparam int WW = F + 2;
  localparam longint ONE_L  = longint'(1) << F;
  localparam longint WMAX_L = (longint'(1) << (WW - 1)) - 1;
  localparam longint WMIN_L = -(longint'(1) << (WW - 1));

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  in_valid;
  logic                  in_ready;
  logic [F-1:0]          frac;
  logic signed [CW-1:0]  coeff_a;
  logic                  mode;
  logic                  out_valid;
  logic                  out_ready;
  logic signed [WW-1:0]  w0, w1, w2, w3;

  int total = 0;
  int bad   = 0;
  int bp_mode = 0;

  logic [4*WW-1:0] exp_q[$];
  logic [4*WW-1:0] cur, held, e;
  logic            stalled_prev = 1'b0;
  int              wsum;

  bicubic_weight_gen #(.FRAC_W(F), .COEF_W(CW), .WGT_W(WW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .frac(frac), .coeff_a(coeff_a), .mode(mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .w0(w0), .w1(w1), .w2(w2), .w3(w3)
  );

  // Clock and consumer readiness
  always #5 clk = ~clk;

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (bp_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: Keys weights from plain integer arithmetic
  function automatic longint rnd(input longint x);
    return (x + (ONE_L >>> 1)) >>> F;
  endfunction

  function automatic longint clamp(input longint x);
    if (x > WMAX_L) return WMAX_L;
    if (x < WMIN_L) return WMIN_L;
    return x;
  endfunction

  function automatic logic [4*WW-1:0] model(input logic [F-1:0] f,
                                            input logic signed [CW-1:0] a,
                                            input logic m);
    longint t, ai, t2, t3, r0, r1, r2, r3;
    t  = longint'(f);
    ai = longint'(a);
    if (m) begin
      r0 = 0;
      r3 = 0;
      r2 = t;
    end else begin
      t2 = rnd(t * t);
      t3 = rnd(t2 * t);
      r0 = rnd(ai * (t3 - 2 * t2 + t));
      r3 = rnd(ai * (t2 - t3));
      r2 = rnd(-ai * t) + rnd((2 * ai + 3 * ONE_L) * t2) + rnd(-(ai + 2 * ONE_L) * t3);
    end
    r0 = clamp(r0);
    r2 = clamp(r2);
    r3 = clamp(r3);
    r1 = clamp(ONE_L - r0 - r2 - r3);
    return {WW'(r0), WW'(r1), WW'(r2), WW'(r3)};
  endfunction

  // Scoreboard / protocol monitor, sampled on the falling edge
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        stalled_prev = 1'b0;
      end else begin
        cur = {w0, w1, w2, w3};
        if (stalled_prev) begin
          check("hold_valid", out_valid, 1);
          check("hold_data", cur, held);
        end
        check("in_ready", in_ready, !(out_valid && !out_ready));
        if (out_valid && out_ready) begin
          check("exp_q_nonempty", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("weights", cur, e);
            wsum = int'(w0) + int'(w1) + int'(w2) + int'(w3);
            check("unity_sum", wsum, ONE_L);
          end
        end
        if (in_valid && in_ready) exp_q.push_back(model(frac, coeff_a, mode));
        stalled_prev = out_valid && !out_ready;
        held = cur;
      end
    end
  end

  // Driver tasks: all start and end #1 after a rising edge
  task automatic send(input logic [F-1:0] f, input logic signed [CW-1:0] a, input logic m);
    int n = 0;
    in_valid = 1'b1;
    frac     = f;
    coeff_a  = a;
    mode     = m;
    forever begin
      @(negedge clk);
      if (in_ready || n > 300) break;
      n++;
    end
    check("send_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(posedge clk);
      n++;
    end
    check("drain_empty", exp_q.size(), 0);
    idle(3);
  endtask

  task automatic expect_set(input logic [F-1:0] f, input logic signed [CW-1:0] a,
                            input logic m, input int e0, input int e1,
                            input int e2, input int e3);
    int lat = 0;
    drain();
    send(f, a, m);
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", lat, 4);
    check("set_w0", w0, e0);
    check("set_w1", w1, e1);
    check("set_w2", w2, e2);
    check("set_w3", w3, e3);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    frac = '0;
    coeff_a = '0;
    mode = 1'b0;
    idle(2);

    // Inputs presented during reset must be ignored
    in_valid = 1'b1;
    frac = 8'd77;
    coeff_a = -11'sd128;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("rst_valid", out_valid, 0);
      check("rst_weights", {w0, w1, w2, w3}, 0);
    end
    in_valid = 1'b0;
    rst = 1'b0;
    check("idle_in_ready", in_ready, 1);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      check("idle_valid", out_valid, 0);
    end

    expect_set(8'd0,   -11'sd128, 1'b0, 0, 256, 0, 0);
    expect_set(8'd128, -11'sd128, 1'b0, -16, 144, 144, -16);
    expect_set(8'd64,  CW'($urandom_range(0, 2047)), 1'b1, 0, 192, 64, 0);
    expect_set(8'd255, CW'($urandom_range(0, 2047)), 1'b1, 0, 1, 255, 0);
    drain();

    // Back-to-back sweep over phases and coefficients
    for (int k = 0; k < 5; k++) begin
      for (int f = 0; f < 256; f++) send(F'(f), CW'(-256 + 64 * k), 1'b0);
    end
    drain();

    // Reset while the output is stalled
    bp_mode = 2;
    idle(1);
    send(8'd100, -11'sd128, 1'b0);
    for (int i = 0; i < 20 && !out_valid; i++) idle(1);
    check("stall_out_valid", out_valid, 1);
    idle(2);
    check("stall_in_ready", in_ready, 0);
    rst = 1'b1;
    idle(1);
    check("stall_rst_valid", out_valid, 0);
    check("stall_rst_weights", {w0, w1, w2, w3}, 0);
    rst = 1'b0;
    bp_mode = 0;
    idle(2);
    drain();

    // Backpressure burst of 20 beats, then a longer random mix
    bp_mode = 1;
    for (int i = 0; i < 20; i++) send(F'($urandom_range(0, 255)), CW'($urandom_range(0, 2047)), 1'b0);
    drain();
    for (int i = 0; i < 200; i++) begin
      send(F'($urandom_range(0, 255)), CW'($urandom_range(0, 2047)), 1'($urandom_range(0, 1)));
      idle($urandom_range(0, 2));
    end
    drain();
    bp_mode = 0;
    idle(2);

    // Reset with three beats in flight; none may emerge afterwards
    send(8'd10, -11'sd128, 1'b0);
    send(8'd20, -11'sd64, 1'b0);
    send(8'd30, 11'sd100, 1'b1);
    rst = 1'b1;
    idle(1);
    check("mid_rst_valid", out_valid, 0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      idle(1);
      check("mid_rst_quiet", out_valid, 0);
    end
    send(8'd200, -11'sd192, 1'b0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
